// File: rtl/radar_sweep_scheduler.sv
// Radar sweep scheduler: waits for calibration, syncs to ARP, tracks ACP azimuth and
// queues one {azimuth, index} request per TRIG. Define RADAR_SWEEP_SCHED_WATCHDOG_EN for the ARP watchdog.
module radar_sweep_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AZ_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESETN,
    input  logic                  ENABLE,
    input  logic                  CALIBRATED,
    input  logic [DATA_WIDTH-1:0] RADAR_ACP_CNT,
    input  logic [DATA_WIDTH-1:0] RADAR_ARP_US,
    input  logic [DATA_WIDTH-1:0] RADAR_TRIG_US,
    input  logic                  RADAR_ARP_PE,
    input  logic                  RADAR_ACP_PE,
    input  logic                  RADAR_TRIG_PE,
    input  logic                  USEC_PE,
    output logic                  SWEEP_VALID,
    input  logic                  SWEEP_READY,
    output logic [AZ_WIDTH-1:0]   SWEEP_AZ,
    output logic [DATA_WIDTH-1:0] SWEEP_IDX,
    output logic [DATA_WIDTH-1:0] SWEEP_LEN_US,
    output logic                  ACTIVE,
    output logic [DATA_WIDTH-1:0] DROP_CNT,
    output logic                  AZ_OVF,
    output logic                  ARP_LOST
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = DATA_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t                state, state_d;
    logic [AZ_WIDTH-1:0]   az_mem  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] idx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, wr_d, rd_ptr, rd_d;
    logic [PTR_W:0]        count, count_d;
    logic [DATA_WIDTH-1:0] idx, idx_d, idx_push;
    logic [DATA_WIDTH-1:0] drop_cnt, drop_d, len, len_d;
    logic [AZ_WIDTH-1:0]   az, az_d, az_next;
    logic [CW-1:0]         az_inc;
    logic                  az_wrap, az_ovf, ovf_d;
    logic                  sweep_valid, active;
    logic                  exit_req, enter_run, live, full;
    logic                  pop, trig_req, push, drop;
    logic                  timeout;

`ifdef RADAR_SWEEP_SCHED_WATCHDOG_EN
    logic [DATA_WIDTH-1:0] usec_cnt;
    logic                  arp_lost;

    // Limit is doubled in one extra bit so large ARP periods cannot wrap.
    assign timeout  = (state == RUN) && (CW'(usec_cnt) > {RADAR_ARP_US, 1'b0});
    assign ARP_LOST = arp_lost;

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            usec_cnt <= '0;
            arp_lost <= 1'b0;
        end else begin
            if (!exit_req && timeout)
                arp_lost <= 1'b1;
            else if (enter_run)
                arp_lost <= 1'b0;

            if (enter_run || (state == RUN && RADAR_ARP_PE) || state != RUN)
                usec_cnt <= '0;
            else if (USEC_PE && usec_cnt != '1)
                usec_cnt <= usec_cnt + DATA_WIDTH'(1);
        end
    end
`else
    logic unused_watchdog;

    assign timeout         = 1'b0;
    assign unused_watchdog = ^{RADAR_ARP_US, USEC_PE};
    assign ARP_LOST        = 1'b0;
`endif

    assign exit_req  = !ENABLE || !CALIBRATED;
    assign enter_run = (state == SYNC) && RADAR_ARP_PE && !exit_req;
    assign live      = (state == RUN) || enter_run;
    assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop       = sweep_valid && SWEEP_READY;
    assign trig_req  = RADAR_TRIG_PE && live && !exit_req && !timeout;
    assign push      = trig_req && (!full || pop);
    assign drop      = trig_req && full && !pop;
    assign idx_push  = enter_run ? '0 : idx;

    always_comb begin
        az_inc  = CW'(az) + CW'(1);
        az_wrap = 1'b0;
        if (RADAR_ARP_PE) begin
            az_next = RADAR_ACP_PE ? AZ_WIDTH'(1) : '0;
        end else if (RADAR_ACP_PE) begin
            if (az_inc >= CW'(RADAR_ACP_CNT)) begin
                az_next = AZ_WIDTH'(RADAR_ACP_CNT - DATA_WIDTH'(1));
                az_wrap = 1'b1;
            end else begin
                az_next = AZ_WIDTH'(az_inc);
            end
        end else begin
            az_next = az;
        end
    end

    always_comb begin
        state_d = state;
        count_d = count;
        wr_d    = wr_ptr;
        rd_d    = rd_ptr;
        idx_d   = idx;
        az_d    = az;
        ovf_d   = az_ovf;
        drop_d  = drop_cnt;
        len_d   = len;
        if (exit_req) begin
            state_d = IDLE;
            count_d = '0;
            wr_d    = '0;
            rd_d    = '0;
        end else if (timeout) begin
            state_d = SYNC;
            count_d = '0;
            wr_d    = '0;
            rd_d    = '0;
        end else begin
            if (state == IDLE)
                state_d = SYNC;
            if (enter_run) begin
                state_d = RUN;
                len_d   = RADAR_TRIG_US;
                ovf_d   = 1'b0;
                idx_d   = '0;
            end
            // The entry ARP goes through the same azimuth/push path as any RUN cycle.
            if (live) begin
                az_d = az_next;
                if (az_wrap)
                    ovf_d = 1'b1;
                if (push) begin
                    wr_d  = wr_ptr + PTR_W'(1);
                    idx_d = idx_push + DATA_WIDTH'(1);
                end
                if (pop)
                    rd_d = rd_ptr + PTR_W'(1);
                if (push && !pop)
                    count_d = count + (PTR_W + 1)'(1);
                else if (pop && !push)
                    count_d = count - (PTR_W + 1)'(1);
                if (drop && drop_cnt != '1)
                    drop_d = drop_cnt + DATA_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state       <= IDLE;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            idx         <= '0;
            az          <= '0;
            az_ovf      <= 1'b0;
            drop_cnt    <= '0;
            len         <= '0;
            sweep_valid <= 1'b0;
            active      <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                az_mem[i]  <= '0;
                idx_mem[i] <= '0;
            end
        end else begin
            state       <= state_d;
            count       <= count_d;
            wr_ptr      <= wr_d;
            rd_ptr      <= rd_d;
            idx         <= idx_d;
            az          <= az_d;
            az_ovf      <= ovf_d;
            drop_cnt    <= drop_d;
            len         <= len_d;
            sweep_valid <= (count_d != '0);
            active      <= (state_d == RUN);
            if (push) begin
                az_mem[wr_ptr]  <= az_next;
                idx_mem[wr_ptr] <= idx_push;
            end
        end
    end

    assign SWEEP_VALID  = sweep_valid;
    assign SWEEP_AZ     = az_mem[rd_ptr];
    assign SWEEP_IDX    = idx_mem[rd_ptr];
    assign SWEEP_LEN_US = len;
    assign ACTIVE       = active;
    assign DROP_CNT     = drop_cnt;
    assign AZ_OVF       = az_ovf;
endmodule
